hazard_ctl: RTL and testbench

HAZARD_CTL -- requirements
Module: hazard_ctl

---
 rtl/simple_pkg.sv | 26 ++
 rtl/sb_entry.sv | 32 +++
 rtl/hazard_ctl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared definitions for the hazard controller.
//   - Forwarding select encodings for the phase-3 operand muxes.
//   - Register-file geometry (NREG registers, REGW-bit register numbers).
//   - sb_entry_t: one scoreboard slot describing an in-flight instruction.
//   - sb_hit(): true when a slot will write a given register.
package simple_pkg;

    localparam int NREG = 8;
    localparam int REGW = $clog2(NREG);

    localparam logic [1:0] FWD_RF    = 2'b00;  // register file
    localparam logic [1:0] FWD_EXMEM = 2'b01;  // phase-4 ALU result
    localparam logic [1:0] FWD_MEMWB = 2'b10;  // phase-5 writeback value

    typedef struct packed {
        logic            valid;
        logic            wr_en;
        logic [REGW-1:0] wr_reg;
        logic            memread;
    } sb_entry_t;

    function automatic logic sb_hit(input sb_entry_t e, input logic [REGW-1:0] r);
        return e.valid && e.wr_en && (e.wr_reg == r);
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot register.
// Ports:
//   clk_i  - rising-edge clock
//   rst_i  - synchronous active-high reset, empties the slot
//   load_i - capture d_i at the next edge
//   clr_i  - load an empty slot instead of d_i (wins over load_i)
//   d_i    - incoming slot contents
//   q_o    - registered slot contents
module sb_entry
    import simple_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      load_i,
    input  logic      clr_i,
    input  sb_entry_t d_i,
    output sb_entry_t q_o
);

    sb_entry_t q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/hazard_ctl.sv
// Hazard controller for a 5-phase in-order pipeline.
// Tracks the destination registers of the instructions in EX, MEM and WB,
// detects load-use hazards and taken branches, and produces registered
// operand-forwarding selects for the instruction entering phase 3.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   id_valid                 - phase-2 holds a real instruction
//   id_ra, id_rb             - phase-2 source registers
//   id_use_ra, id_use_rb     - phase-2 instruction reads Ra / Rb
//   id_wr_en, id_wr_reg      - phase-2 destination write enable / register
//   id_memread               - phase-2 instruction is a load
//   ex_br_taken              - phase-3 instruction is a taken branch
//   stall                    - hold PC and phase-2 register
//   bubble                   - load zero controls into phase-3 register
//   flush                    - clear phase-2 register
//   fwd_a, fwd_b             - operand source for the phase-3 instruction
//   stall_cnt, flush_cnt     - saturating event counters
module hazard_ctl
    import simple_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_ra,
    input  logic [REGW-1:0] id_rb,
    input  logic            id_use_ra,
    input  logic            id_use_rb,
    input  logic            id_wr_en,
    input  logic [REGW-1:0] id_wr_reg,
    input  logic            id_memread,
    input  logic            ex_br_taken,
    output logic            stall,
    output logic            bubble,
    output logic            flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt
);

    sb_entry_t   id_ent;
    sb_entry_t   ex_q;
    sb_entry_t   mem_q;
    sb_entry_t   wb_q;
    logic        load_use;
    logic [1:0]  fwd_a_q, fwd_a_d;
    logic [1:0]  fwd_b_q, fwd_b_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Select for an operand of the instruction now in phase 2, evaluated
    // against where its producers will sit once it reaches phase 3.
    // A load in EX cannot forward its ALU result (that case stalls).
    // A WB producer has already written the write-first register file.
    function automatic logic [1:0] fwd_sel(
        input logic            use_r,
        input logic [REGW-1:0] r,
        input sb_entry_t       ex,
        input sb_entry_t       mem,
        input sb_entry_t       wb
    );
        if (!use_r)                       return FWD_RF;
        if (sb_hit(ex, r) && !ex.memread) return FWD_EXMEM;
        if (sb_hit(mem, r))               return FWD_MEMWB;
        if (sb_hit(wb, r))                return FWD_RF;
        return FWD_RF;
    endfunction

    always_comb begin
        id_ent         = '0;
        id_ent.valid   = id_valid;
        id_ent.wr_en   = id_wr_en;
        id_ent.wr_reg  = id_wr_reg;
        id_ent.memread = id_memread;
    end

    assign load_use = id_valid && ex_q.memread &&
                      ((id_use_ra && sb_hit(ex_q, id_ra)) ||
                       (id_use_rb && sb_hit(ex_q, id_rb)));

    // A taken branch kills the phase-2 instruction anyway, so it overrides
    // any load-use stall against that instruction.
    assign flush  = ex_br_taken;
    assign stall  = load_use && !ex_br_taken;
    assign bubble = stall || flush;

    // Scoreboard always advances; a bubble enters EX on stall or flush.
    sb_entry u_ex (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (1'b1),
        .clr_i  (bubble),
        .d_i    (id_ent),
        .q_o    (ex_q)
    );

    sb_entry u_mem (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (1'b1),
        .clr_i  (1'b0),
        .d_i    (ex_q),
        .q_o    (mem_q)
    );

    sb_entry u_wb (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (1'b1),
        .clr_i  (1'b0),
        .d_i    (mem_q),
        .q_o    (wb_q)
    );

    always_comb begin
        fwd_a_d     = bubble ? FWD_RF : fwd_sel(id_use_ra, id_ra, ex_q, mem_q, wb_q);
        fwd_b_d     = bubble ? FWD_RF : fwd_sel(id_use_rb, id_rb, ex_q, mem_q, wb_q);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: directed pipeline scenarios followed by random
// traffic, every cycle compared against a reference model that tracks the
// last three instructions issued into phase 3.
module tb_hazard_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_ra, id_rb;
    logic        id_use_ra, id_use_rb;
    logic        id_wr_en;
    logic [2:0]  id_wr_reg;
    logic        id_memread;
    logic        ex_br_taken;
    logic        stall, bubble, flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    hazard_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_ra       (id_ra),
        .id_rb       (id_rb),
        .id_use_ra   (id_use_ra),
        .id_use_rb   (id_use_rb),
        .id_wr_en    (id_wr_en),
        .id_wr_reg   (id_wr_reg),
        .id_memread  (id_memread),
        .ex_br_taken (ex_br_taken),
        .stall       (stall),
        .bubble      (bubble),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    // clock
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // older[0] is the instruction now in phase 3, older[1] in phase 4,
    // older[2] in phase 5.
    typedef struct {
        bit valid;
        bit wr_en;
        bit memread;
        int dst;
    } instr_t;

    instr_t older[3];
    int     m_fa, m_fb;
    int     m_sc, m_fc;
    bit     live;

    function automatic bit writes(instr_t p, int r);
        return p.valid && p.wr_en && (p.dst == r);
    endfunction

    // Distance 1 producer forwards its ALU result unless it is a load;
    // distance 2 producer forwards its writeback value; older is in the RF.
    function automatic int exp_src(bit use_r, int r);
        if (!use_r) return 0;
        if (writes(older[0], r) && !older[0].memread) return 1;
        if (writes(older[1], r)) return 2;
        return 0;
    endfunction

    function automatic bit exp_stall();
        if (ex_br_taken || !id_valid || !older[0].memread) return 0;
        return (id_use_ra && writes(older[0], int'(id_ra))) ||
               (id_use_rb && writes(older[0], int'(id_rb)));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drv(input logic v, input logic [2:0] ra, input logic [2:0] rb,
                       input logic ua, input logic ub, input logic we,
                       input logic [2:0] wd, input logic mr, input logic br);
        id_valid    = v;
        id_ra       = ra;
        id_rb       = rb;
        id_use_ra   = ua;
        id_use_rb   = ub;
        id_wr_en    = we;
        id_wr_reg   = wd;
        id_memread  = mr;
        ex_br_taken = br;
    endtask

    // Combinational outputs, checked between edges.
    task automatic settle();
        logic s;
        #1;
        if (live) begin
            s = exp_stall();
            chk("stall", 16'(stall), 16'(s));
            chk("bubble", 16'(bubble), 16'(s || ex_br_taken));
            chk("flush", 16'(flush), 16'(ex_br_taken));
        end
    endtask

    // One clock edge: advance the model, then check registered outputs.
    task automatic tick();
        bit s, f;
        int na, nb;
        s  = exp_stall();
        f  = ex_br_taken;
        na = exp_src(id_use_ra, int'(id_ra));
        nb = exp_src(id_use_rb, int'(id_rb));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                older[i].valid = 0; older[i].wr_en = 0; older[i].memread = 0; older[i].dst = 0;
            end
            m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
            live = 1;
        end else begin
            m_fa = (s || f) ? 0 : na;
            m_fb = (s || f) ? 0 : nb;
            if (s && m_sc < 65535) m_sc++;
            if (f && m_fc < 65535) m_fc++;
            older[2] = older[1];
            older[1] = older[0];
            if (s || f) begin
                older[0].valid = 0; older[0].wr_en = 0; older[0].memread = 0; older[0].dst = 0;
            end else begin
                older[0].valid   = id_valid;
                older[0].wr_en   = id_wr_en;
                older[0].memread = id_memread;
                older[0].dst     = int'(id_wr_reg);
            end
        end
        #1;
        if (live) begin
            chk("fwd_a", 16'(fwd_a), 16'(m_fa));
            chk("fwd_b", 16'(fwd_b), 16'(m_fb));
            chk("stall_cnt", stall_cnt, 16'(m_sc));
            chk("flush_cnt", flush_cnt, 16'(m_fc));
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        live = 0;
        for (int i = 0; i < 3; i++) begin
            older[i].valid = 0; older[i].wr_en = 0; older[i].memread = 0; older[i].dst = 0;
        end
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;

        // reset
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); tick();
        settle(); tick();
        chk("rst_fwd_a", 16'(fwd_a), 16'h0);
        chk("rst_fwd_b", 16'(fwd_b), 16'h0);
        chk("rst_stall_cnt", stall_cnt, 16'h0);
        chk("rst_flush_cnt", flush_cnt, 16'h0);
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("post_rst_stall", 16'(stall), 16'h0); tick();

        // load-use: LD r3 ; ADD r4 = r1 + r3
        drv(1, 0, 0, 1, 0, 1, 3, 1, 0); settle(); tick();
        drv(1, 1, 3, 1, 1, 1, 4, 0, 0); settle();
        chk("lu_stall", 16'(stall), 16'h1);
        chk("lu_bubble", 16'(bubble), 16'h1);
        tick();
        settle();
        chk("lu_one_cycle", 16'(stall), 16'h0);
        tick();
        chk("lu_fwd_b", 16'(fwd_b), 16'h2);
        chk("lu_cnt", stall_cnt, 16'h1);

        // ALU chain: ADD r2 ; SUB r5 = r2 - r6
        drv(1, 1, 0, 1, 0, 1, 2, 0, 0); settle(); tick();
        drv(1, 2, 6, 1, 1, 1, 5, 0, 0); settle();
        chk("alu_nostall", 16'(stall), 16'h0);
        tick();
        chk("alu_fwd_a", 16'(fwd_a), 16'h1);

        // ADD r2 ; OR r7 (independent) ; SUB r6 = r2 - r0
        drv(1, 1, 0, 1, 0, 1, 2, 0, 0); settle(); tick();
        drv(1, 0, 0, 1, 0, 1, 7, 0, 0); settle(); tick();
        drv(1, 2, 0, 1, 0, 1, 6, 0, 0); settle(); tick();
        chk("gap_fwd_a", 16'(fwd_a), 16'h2);

        // double hit: r5 in EX and MEM
        drv(1, 0, 0, 1, 0, 1, 5, 0, 0); settle(); tick();
        drv(1, 1, 0, 1, 0, 1, 5, 0, 0); settle(); tick();
        drv(1, 5, 5, 1, 1, 1, 1, 0, 0); settle(); tick();
        chk("dbl_fwd_a", 16'(fwd_a), 16'h1);
        chk("dbl_fwd_b", 16'(fwd_b), 16'h1);

        // branch taken alongside a load-use condition
        drv(1, 0, 0, 1, 0, 1, 3, 1, 0); settle(); tick();
        drv(1, 3, 0, 1, 0, 1, 4, 0, 1); settle();
        chk("br_flush", 16'(flush), 16'h1);
        chk("br_bubble", 16'(bubble), 16'h1);
        chk("br_stall", 16'(stall), 16'h0);
        tick();
        chk("br_flush_cnt", flush_cnt, 16'h1);
        chk("br_stall_cnt", stall_cnt, 16'h1);
        chk("br_fwd_a", 16'(fwd_a), 16'h0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); settle(); tick();

        // saturation: preload counter, then three stalls (LD r3,[r3] repeated)
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        m_sc = 16'hFFFE;
        for (int i = 0; i < 6; i++) begin
            drv(1, 3, 0, 1, 0, 1, 3, 1, 0); settle(); tick();
        end
        chk("sat_cnt", stall_cnt, 16'hFFFF);

        // reset during a stall
        drv(1, 3, 0, 1, 0, 1, 3, 1, 0); settle(); tick();
        rst = 1'b1;
        settle(); tick();
        chk("midrst_fwd_a", 16'(fwd_a), 16'h0);
        chk("midrst_fwd_b", 16'(fwd_b), 16'h0);
        chk("midrst_stall_cnt", stall_cnt, 16'h0);
        chk("midrst_flush_cnt", flush_cnt, 16'h0);
        rst = 1'b0;
        settle();
        chk("midrst_stall", 16'(stall), 16'h0);
        chk("midrst_bubble", 16'(bubble), 16'h0);
        chk("midrst_flush", 16'(flush), 16'h0);
        tick();

        // random traffic over a small register set so hits are frequent
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            drv(($urandom_range(0, 7) != 0),
                3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
            settle(); tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
